riscv_str_seq: RTL
==================

// Module: riscv_str_seq
// PURPOSE
//  Command-driven sequencer that streams a word buffer from memory through the riscv_str_ops datapath and writes results back.
//  Accepts one command (operator, src, dst, length in words); per word: read, execute on str_ops (1-cycle registered unit), write back.
//  Sits beside the core as a memory master on a req/gnt/rvalid data port; riscv_str_ops is instantiated next to it by the parent.
// PARAMETERS
//  LEN_W   16  width of word-count field; max transfer 2**LEN_W-1 words
// PORTS
//  clk             in   1             clock, all state on posedge
//  rst             in   1             asynchronous reset, active-high
//  cmd_valid_i     in   1             command offered
//  cmd_ready_o     out  1             high only in IDLE
//  cmd_op_i        in   STR_OP_WIDTH  operator, passed to str_op_o
//  cmd_src_i       in   32            source byte address; bits[1:0] ignored (forced 0)
//  cmd_dst_i       in   32            destination byte address; bits[1:0] ignored
//  cmd_len_i       in   LEN_W         number of words
//  abort_i         in   1             request early stop (sticky until DONE)
//  busy_o          out  1             high in every state except IDLE
//  done_o          out  1             one-cycle pulse in DONE
//  aborted_o       out  1             valid with done_o: sequence ended by abort
//  words_done_o    out  LEN_W         words written back in current/last command
//  data_req_o/data_gnt_i/data_rvalid_i  out/in/in 1   memory handshake, one outstanding transaction
//  data_addr_o     out  32            word-aligned address
//  data_we_o       out  1             1 = write
//  data_be_o       out  4             byte enables (writes); 4'hF on reads
//  data_wdata_o    out  32            = str_result_i during WR_REQ
//  data_rdata_i    in   32            read data, sampled when data_rvalid_i
//  str_en_o        out  1             enable_i of riscv_str_ops
//  str_op_o        out  STR_OP_WIDTH  operator_i of riscv_str_ops
//  str_operand_o   out  32            operand_i, registered read word
//  str_result_i    in   32            result_o of riscv_str_ops
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except cmd_ready_o=1; internal addr/count/operand regs 0; sticky abort cleared.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> EXEC -> WR_REQ -> WR_WAIT -> (RD_REQ | DONE) ; DONE -> IDLE.
//  IDLE: cmd_valid_i&cmd_ready_o latches cmd; len==0 -> DONE directly (no memory access), else RD_REQ.
//  RD_REQ/WR_REQ: req held high with stable addr/we/be/wdata until gnt; advance on gnt.
//  RD_WAIT: on rvalid latch data_rdata_i into operand reg -> EXEC. WR_WAIT: on rvalid -> word complete.
//  EXEC: str_en_o=1 for exactly one cycle; result valid the following cycle and held (str_en_o low).
//  Word complete: src+=4, dst+=4 (32-bit wrap), words_done_o+=1; DONE if count reached or abort pending, else RD_REQ.
//  Min throughput (gnt same cycle, rvalid next): 5 cycles/word; done_o 1 cycle after last write rvalid.
//  abort_i: honoured only at word completion or in IDLE->len path; never mid-handshake. aborted_o=1 with done_o.
//  cmd_valid_i while busy: ignored (ready low). abort_i in IDLE: ignored.
//  Mid-operation reset: immediate return to IDLE, outstanding bus transaction abandoned (bus owner's concern).
// CONFIGURATION
//  STR_SEQ_NUL_STOP_EN defined: NUL detection on each read word (lowest byte first); if byte k is 0x00,
//   write uses data_be_o with bytes 0..k set, sequence ends after that word (done_o, aborted_o=0).
//  Undefined: data_be_o=4'hF on all writes; termination by length/abort only.
// STRUCTURE
//  riscv_defines: add str_seq_state_e enum (IDLE,RD_REQ,RD_WAIT,EXEC,WR_REQ,WR_WAIT,DONE), nul_be(word) function.
//  Single module, no sub-module; str_ops instance and bus arbitration live in the parent.
// TESTING
//  len=0, op=UPPER -> done_o 1 cycle after accept, no data_req_o, words_done_o=0.
//  len=2 UPPER, src 0x100 {"abcd","wxyz"}, dst 0x200, gnt same cycle -> writes "ABCD","WXYZ" at 0x200/0x204, 10 cycles.
//  len=1 LOWER, gnt delayed 3 cycles on both req -> addr/wdata stable throughout, "AbC1"->"abc1".
//  len=4, abort_i pulsed during 2nd word EXEC -> exactly 2 writes, done_o&aborted_o, words_done_o=2.
//  NUL_STOP_EN, len=3, word0=0x00_63_62_61 -> write be=4'hF? no: be=4'hF only if NUL absent; here be=4'b1111->NUL at byte3, be=4'hF, stop after 1 word.
//  rst asserted in WR_REQ -> next cycle IDLE, req low, cmd_ready_o=1; new command runs normally.

Source files
------------

// File: rtl/riscv_str_seq_pkg.sv
// Shared types and helpers for the string-op sequencer: operator codes, FSM states, NUL byte-enable helpers.
// The NUL-stop feature (macro STR_SEQ_NUL_STOP_EN) relies on nul_be/has_nul below.
package riscv_str_seq_pkg;

    localparam int STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_PASS  = 2'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_SWAP  = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        EXEC    = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6
    } str_seq_state_e;

    // Byte enables covering bytes 0..k where byte k is the lowest NUL; all ones if none.
    function automatic logic [3:0] nul_be(input logic [31:0] word);
        logic found;
        nul_be = 4'hF;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && word[8*k +: 8] == 8'h00) begin
                found  = 1'b1;
                nul_be = 4'hF >> (3 - k);
            end
        end
    endfunction

    function automatic logic has_nul(input logic [31:0] word);
        has_nul = (word[7:0] == 8'h00) || (word[15:8] == 8'h00) ||
                  (word[23:16] == 8'h00) || (word[31:24] == 8'h00);
    endfunction

endpackage

// File: rtl/riscv_str_seq_if.sv
// Data-port bus between the sequencer (master) and memory (slave):
// req/gnt address phase, rvalid response phase, one transaction outstanding.
interface riscv_str_seq_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/riscv_str_seq.sv
// Command-driven sequencer: read word, run it through the external str_ops unit, write it back.
// Optional STR_SEQ_NUL_STOP_EN: stop after the first word holding a NUL byte, writing bytes up to it.
module riscv_str_seq
    import riscv_str_seq_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [STR_OP_WIDTH-1:0] cmd_op_i,
    input  logic [31:0]             cmd_src_i,
    input  logic [31:0]             cmd_dst_i,
    input  logic [LEN_W-1:0]        cmd_len_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o,
    output logic [LEN_W-1:0]        words_done_o,
    riscv_str_seq_if.master         data,
    output logic                    str_en_o,
    output logic [STR_OP_WIDTH-1:0] str_op_o,
    output logic [31:0]             str_operand_o,
    input  logic [31:0]             str_result_i
);

    str_seq_state_e          state_reg, state_next;
    logic [STR_OP_WIDTH-1:0] op_reg;
    logic [31:0]             src_reg, dst_reg, operand_reg;
    logic [LEN_W-1:0]        len_reg, cnt_reg;
    logic                    abort_pend_reg, aborted_reg, nul_stop_reg;
    logic [3:0]              be_reg;
    logic                    last_word, stop_now;

    assign last_word = (cnt_reg + LEN_W'(1)) == len_reg;
    assign stop_now  = last_word || abort_pend_reg || abort_i || nul_stop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_valid_i) state_next = (cmd_len_i == '0) ? DONE : RD_REQ;
            RD_REQ:  if (data.gnt)    state_next = RD_WAIT;
            RD_WAIT: if (data.rvalid) state_next = EXEC;
            EXEC:                     state_next = WR_REQ;
            WR_REQ:  if (data.gnt)    state_next = WR_WAIT;
            WR_WAIT: if (data.rvalid) state_next = stop_now ? DONE : RD_REQ;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg         <= '0;
            src_reg        <= '0;
            dst_reg        <= '0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            operand_reg    <= '0;
            abort_pend_reg <= 1'b0;
            aborted_reg    <= 1'b0;
            nul_stop_reg   <= 1'b0;
            be_reg         <= 4'hF;
        end else begin
            case (state_reg)
                IDLE: if (cmd_valid_i) begin
                    op_reg         <= cmd_op_i;
                    src_reg        <= {cmd_src_i[31:2], 2'b00};
                    dst_reg        <= {cmd_dst_i[31:2], 2'b00};
                    len_reg        <= cmd_len_i;
                    cnt_reg        <= '0;
                    abort_pend_reg <= 1'b0;
                    aborted_reg    <= 1'b0;
                    nul_stop_reg   <= 1'b0;
                    be_reg         <= 4'hF;
                end
                RD_WAIT: if (data.rvalid) begin
                    operand_reg <= data.rdata;
`ifdef STR_SEQ_NUL_STOP_EN
                    be_reg       <= nul_be(data.rdata);
                    nul_stop_reg <= has_nul(data.rdata);
`else
                    be_reg       <= 4'hF;
                    nul_stop_reg <= 1'b0;
`endif
                end
                WR_WAIT: if (data.rvalid) begin
                    src_reg <= src_reg + 32'd4;
                    dst_reg <= dst_reg + 32'd4;
                    cnt_reg <= cnt_reg + LEN_W'(1);
                    // An abort landing on the final word, or a NUL stop, is a normal finish.
                    aborted_reg <= (abort_pend_reg || abort_i) && !last_word && !nul_stop_reg;
                end
                DONE: abort_pend_reg <= 1'b0;
                default: ;
            endcase
            if (abort_i && state_reg != IDLE && state_reg != DONE)
                abort_pend_reg <= 1'b1;
        end
    end

    always_comb begin
        cmd_ready_o   = (state_reg == IDLE);
        busy_o        = (state_reg != IDLE);
        done_o        = (state_reg == DONE);
        aborted_o     = (state_reg == DONE) && aborted_reg;
        words_done_o  = cnt_reg;
        str_en_o      = (state_reg == EXEC);
        str_op_o      = op_reg;
        str_operand_o = operand_reg;
        data.req      = (state_reg == RD_REQ) || (state_reg == WR_REQ);
        data.we       = (state_reg == WR_REQ);
        data.addr     = '0;
        data.be       = 4'h0;
        data.wdata    = '0;
        if (state_reg == RD_REQ) begin
            data.addr = src_reg;
            data.be   = 4'hF;
        end else if (state_reg == WR_REQ) begin
            data.addr  = dst_reg;
            data.be    = be_reg;
            data.wdata = str_result_i;
        end
    end

endmodule
